// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// instr_fetch : PC walker issuing ROM reads, valid/ready hand-off to decode.
// Revision    : 1.0
// ============================================================================
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0,
   parameter int          ROM_BYTES = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fetch_enable,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] rom_address,
   output logic        rom_enable,
   input  logic [31:0] rom_data,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc,
   output logic [31:0] fetch_count,
   output logic        fault
);

   localparam logic [31:0] LAST_ADDR = 32'(ROM_BYTES - 4);

   typedef enum logic [1:0] {
      S_FETCH = 2'd0,
      S_WAIT  = 2'd1,
      S_FAULT = 2'd2
   } state_t;

   state_t      state, state_next;
   logic [31:0] pc, pc_next;
   logic [31:0] count, count_next;
   logic        rom_enable_raw;
   logic        instr_valid_raw;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= S_FETCH;
         pc    <= RESET_PC;
         count <= 32'd0;
      end else begin
         state <= state_next;
         pc    <= pc_next;
         count <= count_next;
      end
   end

   always_comb begin
      state_next      = state;
      pc_next         = pc;
      count_next      = count;
      rom_enable_raw  = 1'b0;
      instr_valid_raw = 1'b0;
      case (state)
         S_FETCH: begin
            if (redirect_valid) begin
               if (redirect_pc[1:0] != 2'b00) state_next = S_FAULT;
               else                           pc_next    = redirect_pc;
            end else if (pc > LAST_ADDR) begin
               // Range is checked before issue so the PC never wraps past the end.
               state_next = S_FAULT;
            end else if (fetch_enable) begin
               rom_enable_raw = 1'b1;
               state_next     = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect_valid) begin
               // Pending word is dropped; no handshake can happen this cycle.
               if (redirect_pc[1:0] != 2'b00) begin
                  state_next = S_FAULT;
               end else begin
                  pc_next    = redirect_pc;
                  state_next = S_FETCH;
               end
            end else begin
               instr_valid_raw = 1'b1;
               if (instr_ready) begin
                  pc_next    = pc + 32'd4;
                  count_next = count + 32'd1;
                  state_next = S_FETCH;
               end
            end
         end
         S_FAULT: begin
            state_next = S_FAULT;
         end
         default: begin
            state_next = S_FAULT;
         end
      endcase
   end

   // Gate strobes with reset so they are quiet for the whole reset pulse.
   assign rom_enable  = rom_enable_raw  & ~reset;
   assign instr_valid = instr_valid_raw & ~reset;
   assign rom_address = pc;
   assign instr_pc    = pc;
   assign instr_data  = rom_data;
   assign fetch_count = count;
   assign fault       = (state == S_FAULT);

endmodule
`default_nettype wire
